// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: level geometry and the valid/last sideband.
package adder_tree_pkg;

    typedef struct packed {
        logic valid;
        logic last;
    } side_t;

    function automatic int tree_levels(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Number of operands remaining after k pairwise levels: ceil(n / 2^k).
    function automatic int level_count(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

    function automatic int treg_count(input int n, input int reg_every);
        return (tree_levels(n) + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/adder_tree_pipelined_acc_tree_level_reg.sv
// One pairwise-add tree level: odd trailing operand passes through, width grows by one bit,
// optional output register advancing only on en.
module tree_level_reg
    import adder_tree_pkg::*;
#(
    parameter int IN_CNT = 2,
    parameter int W = 8,
    parameter bit SIGNED = 1'b0,
    parameter bit REGISTERED = 1'b1,
    localparam int OUT_CNT = (IN_CNT + 1) / 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] in_data [IN_CNT],
    input  side_t        in_side,
    output logic [W:0]   out_data [OUT_CNT],
    output side_t        out_side
);

    logic [W:0] sum [OUT_CNT];

    function automatic logic [W:0] ext(input logic [W-1:0] v);
        return {(SIGNED ? v[W-1] : 1'b0), v};
    endfunction

    for (genvar j = 0; j < OUT_CNT; j++) begin : g_pair
        if (2 * j + 1 < IN_CNT) begin : g_add
            assign sum[j] = ext(in_data[2*j]) + ext(in_data[2*j+1]);
        end else begin : g_pass
            assign sum[j] = ext(in_data[2*j]);
        end
    end

    if (REGISTERED) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_side <= '0;
                out_data <= '{default: '0};
            end else if (en) begin
                out_side <= in_side;
                out_data <= sum;
            end
        end
    end else begin : g_comb
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, en};
        assign out_data = sum;
        assign out_side = in_side;
    end

endmodule

// File: rtl/adder_tree_pipelined_acc.sv
// Pipelined N-lane adder tree feeding a group accumulator delimited by in_last.
// Define ADDER_TREE_SAT_EN for a saturating accumulator with a sticky out_sat port.
module adder_tree_pipelined_acc
    import adder_tree_pkg::*;
#(
    parameter int N = 8,
    parameter int IN_WIDTH = 32,
    parameter bit SIGNED = 1'b0,
    parameter int REG_EVERY = 1,
    parameter int ACC_WIDTH = IN_WIDTH + $clog2(N) + 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data [N],
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count
`ifdef ADDER_TREE_SAT_EN
    ,
    output logic                 out_sat
`endif
);

    localparam int LEVELS = tree_levels(N);
    localparam int TW = IN_WIDTH + LEVELS;
    localparam int M = ACC_WIDTH - 1;

    logic                 en;
    side_t                in_side;
    logic [TW-1:0]        tree_sum;
    side_t                tree_side;
    logic [ACC_WIDTH-1:0] tree_ext;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign en = !out_valid || out_ready;
    assign in_ready = en;
    assign in_side.valid = in_valid && en;
    assign in_side.last = in_last;

    if (LEVELS == 0) begin : g_flat
        assign tree_sum = in_data[0];
        assign tree_side = in_side;
    end else begin : g_tree
        for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
            localparam int CNT_IN = level_count(N, k);
            localparam int CNT_OUT = level_count(N, k + 1);
            localparam int W = IN_WIDTH + k;
            logic [W-1:0] src [CNT_IN];
            side_t        src_side;
            logic [W:0]   data [CNT_OUT];
            side_t        side;

            if (k == 0) begin : g_first
                assign src = in_data;
                assign src_side = in_side;
            end else begin : g_next
                assign src = g_lvl[k-1].data;
                assign src_side = g_lvl[k-1].side;
            end

            tree_level_reg #(
                .IN_CNT    (CNT_IN),
                .W         (W),
                .SIGNED    (SIGNED),
                .REGISTERED(((k + 1) % REG_EVERY == 0) || (k == LEVELS - 1))
            ) u_level (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .in_data (src),
                .in_side (src_side),
                .out_data(data),
                .out_side(side)
            );
        end
        assign tree_sum = g_lvl[LEVELS-1].data[0];
        assign tree_side = g_lvl[LEVELS-1].side;
    end

    function automatic logic [ACC_WIDTH-1:0] widen(input logic [TW-1:0] v);
        logic signed [TW-1:0] sv;
        sv = v;
        if (SIGNED) return ACC_WIDTH'(sv);
        return ACC_WIDTH'(v);
    endfunction

    assign tree_ext = widen(tree_sum);
    assign cnt_inc = cnt + CNT_WIDTH'(1);

`ifdef ADDER_TREE_SAT_EN
    logic acc_ovf;
    logic sat_acc;

    function automatic logic add_ovf(input logic [ACC_WIDTH-1:0] a, input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] wide;
        logic [ACC_WIDTH-1:0] s;
        wide = {1'b0, a} + {1'b0, b};
        s = wide[ACC_WIDTH-1:0];
        if (SIGNED) return (a[M] == b[M]) && (s[M] != a[M]);
        return wide[ACC_WIDTH];
    endfunction

    // On overflow both operands share a sign, so the accumulator's sign picks the rail.
    function automatic logic [ACC_WIDTH-1:0] sat_value(input logic [ACC_WIDTH-1:0] a);
        if (!SIGNED) return '1;
        return a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
    endfunction

    assign acc_ovf = add_ovf(acc, tree_ext);
    assign acc_sum = acc_ovf ? sat_value(acc) : acc + tree_ext;
`else
    assign acc_sum = acc + tree_ext;
`endif

    // accumulator / output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
`ifdef ADDER_TREE_SAT_EN
            sat_acc   <= 1'b0;
            out_sat   <= 1'b0;
`endif
        end else if (en) begin
            if (tree_side.valid && tree_side.last) begin
                out_sum   <= acc_sum;
                out_count <= cnt_inc;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
`ifdef ADDER_TREE_SAT_EN
                out_sat   <= sat_acc | acc_ovf;
                sat_acc   <= 1'b0;
`endif
            end else begin
                out_valid <= 1'b0;
                if (tree_side.valid) begin
                    acc <= acc_sum;
                    cnt <= cnt_inc;
`ifdef ADDER_TREE_SAT_EN
                    sat_acc <= sat_acc | acc_ovf;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_pipelined_acc.sv
// Bench for adder_tree_pipelined_acc: three configurations, group-sum scoreboard on the N=8 instance.
module tb_adder_tree_pipelined_acc;

    localparam int AW_A = 43;
    localparam int AW_B = 19;
    localparam int AW_C = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   failures = 0;

    logic            a_valid, a_ready, a_last, a_ovalid, a_oready;
    logic [31:0]     a_data [8];
    logic [AW_A-1:0] a_sum;
    logic [15:0]     a_count;

    logic            b_valid, b_ready, b_last, b_ovalid, b_oready;
    logic [7:0]      b_data [5];
    logic [AW_B-1:0] b_sum;
    logic [15:0]     b_count;

    logic            c_valid, c_ready, c_last, c_ovalid, c_oready;
    logic [7:0]      c_data [2];
    logic [AW_C-1:0] c_sum;
    logic [1:0]      c_count;

`ifdef ADDER_TREE_SAT_EN
    logic a_sat, b_sat, c_sat;
`endif

    adder_tree_pipelined_acc #(.N(8), .IN_WIDTH(32), .SIGNED(1'b0), .REG_EVERY(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_last(a_last), .out_valid(a_ovalid), .out_ready(a_oready), .out_sum(a_sum),
        .out_count(a_count)
`ifdef ADDER_TREE_SAT_EN
        , .out_sat(a_sat)
`endif
    );

    adder_tree_pipelined_acc #(.N(5), .IN_WIDTH(8), .SIGNED(1'b1), .REG_EVERY(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_last(b_last), .out_valid(b_ovalid), .out_ready(b_oready), .out_sum(b_sum),
        .out_count(b_count)
`ifdef ADDER_TREE_SAT_EN
        , .out_sat(b_sat)
`endif
    );

    adder_tree_pipelined_acc #(.N(2), .IN_WIDTH(8), .SIGNED(1'b0), .REG_EVERY(1),
                               .ACC_WIDTH(AW_C), .CNT_WIDTH(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
        .in_last(c_last), .out_valid(c_ovalid), .out_ready(c_oready), .out_sum(c_sum),
        .out_count(c_count)
`ifdef ADDER_TREE_SAT_EN
        , .out_sat(c_sat)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Group-level model for dut_a: sum each accepted vector's lanes, emit on last.
    logic [AW_A-1:0] m_acc;
    logic [15:0]     m_cnt;
    logic [AW_A-1:0] q_sum [$];
    logic [15:0]     q_cnt [$];
    int              groups_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_acc = '0;
            m_cnt = '0;
            q_sum.delete();
            q_cnt.delete();
        end else begin
            if (a_ovalid && a_oready) begin
                if (q_sum.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got sum 0x%0h count %0d with no group pending", a_sum, a_count);
                end else begin
                    check("sb_sum", a_sum, q_sum.pop_front());
                    check("sb_count", a_count, q_cnt.pop_front());
                    groups_seen++;
                end
            end
            if (a_valid && a_ready) begin
                for (int i = 0; i < 8; i++) m_acc = m_acc + {11'b0, a_data[i]};
                m_cnt = m_cnt + 16'd1;
                if (a_last) begin
                    q_sum.push_back(m_acc);
                    q_cnt.push_back(m_cnt);
                    m_acc = '0;
                    m_cnt = '0;
                end
            end
        end
    end

    task automatic send_a(input int base, input int step, input logic last);
        int waited = 0;
        for (int i = 0; i < 8; i++) a_data[i] = 32'(base + i * step);
        a_last = last;
        a_valid = 1'b1;
        @(negedge clk);
        while (!a_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!a_ready) begin
            checks++;
            failures++;
            $display("FAIL send_a_timeout: in_ready got 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_last = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] l0, l1, l2, l3, l4, input logic last);
        b_data[0] = l0; b_data[1] = l1; b_data[2] = l2; b_data[3] = l3; b_data[4] = l4;
        b_last = last;
        b_valid = 1'b1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_last = 1'b0;
    endtask

    task automatic send_c(input logic [7:0] l0, l1, input logic last);
        c_data[0] = l0;
        c_data[1] = l1;
        c_last = last;
        c_valid = 1'b1;
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        c_last = 1'b0;
    endtask

    task automatic wait_a(output int n);
        n = 1;
        while (!a_ovalid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation got no finish, expected finish before 300000");
        $fatal(1);
    end

    initial begin
        int lat;
        int g0;
        rst = 1'b1;
        a_valid = 0; a_last = 0; a_oready = 1;
        b_valid = 0; b_last = 0; b_oready = 1;
        c_valid = 0; c_last = 0; c_oready = 1;
        for (int i = 0; i < 8; i++) a_data[i] = '0;
        for (int i = 0; i < 5; i++) b_data[i] = '0;
        for (int i = 0; i < 2; i++) c_data[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", a_ovalid, 0);
        check("rst_out_sum", a_sum, 0);
        check("rst_out_count", a_count, 0);
`ifdef ADDER_TREE_SAT_EN
        check("rst_out_sat", a_sat, 0);
`endif
        rst = 1'b0;
        check("rst_in_ready", a_ready, 1);

        // single vector 1..8
        send_a(1, 1, 1'b1);
        wait_a(lat);
        check("lat_a", lat, 4);
        check("single_sum", a_sum, 36);
        check("single_count", a_count, 1);
        @(posedge clk);
        #1;
        check("single_clear", a_ovalid, 0);

        // 3-vector all-ones group then 1-vector all-twos group, back-to-back
        send_a(1, 0, 1'b0);
        send_a(1, 0, 1'b0);
        send_a(1, 0, 1'b1);
        send_a(2, 0, 1'b1);
        wait_a(lat);
        check("b2b_first_sum", a_sum, 24);
        check("b2b_first_count", a_count, 3);
        @(posedge clk);
        #1;
        check("b2b_second_valid", a_ovalid, 1);
        check("b2b_second_sum", a_sum, 16);
        check("b2b_second_count", a_count, 1);

        // downstream stall for 5 cycles while the producer keeps pushing
        repeat (3) @(posedge clk);
        #1;
        g0 = groups_seen;
        a_oready = 1'b0;
        fork
            begin
                send_a(3, 1, 1'b1);
                send_a(5, 2, 1'b0);
                send_a(7, 0, 1'b1);
                send_a(1, 1, 1'b1);
                send_a(9, 3, 1'b0);
                send_a(4, 0, 1'b0);
                send_a(2, 5, 1'b1);
            end
            begin
                wait_a(lat);
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check("stall_in_ready", a_ready, 0);
                    check("stall_sum", a_sum, 52);
                    check("stall_count", a_count, 1);
                end
                a_oready = 1'b1;
            end
        join
        repeat (15) @(posedge clk);
        #1;
        check("stall_groups", groups_seen - g0, 4);
        check("stall_drained", q_sum.size(), 0);

        // reset in the middle of a group discards the partial sum
        send_a(1, 1, 1'b0);
        send_a(2, 1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", a_ovalid, 0);
        check("midrst_out_sum", a_sum, 0);
        check("midrst_out_count", a_count, 0);
        rst = 1'b0;
        check("midrst_in_ready", a_ready, 1);
        send_a(1, 1, 1'b1);
        wait_a(lat);
        check("midrst_sum", a_sum, 36);
        check("midrst_count", a_count, 1);

        // signed N=5, odd lane count, register every 2 levels
        send_b(8'h80, 8'hFF, 8'h7F, 8'h03, 8'hFE, 1'b1);
        lat = 1;
        while (!b_ovalid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("lat_b", lat, 3);
        check("signed_sum", b_sum, 19'h7FFFF);
        check("signed_count", b_count, 1);
        send_b(8'h80, 8'hFF, 8'h7F, 8'h03, 8'hFE, 1'b0);
        send_b(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1);
        lat = 0;
        while (!b_ovalid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("signed_group_sum", b_sum, 19'h7FD7F);
        check("signed_group_count", b_count, 2);

        // N=2, 10-bit accumulator: overflow handling and 2-bit count wrap
        send_c(8'd255, 8'd255, 1'b0);
        send_c(8'd255, 8'd255, 1'b0);
        send_c(8'd255, 8'd255, 1'b1);
        lat = 0;
        while (!c_ovalid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
`ifdef ADDER_TREE_SAT_EN
        check("ovf_sum", c_sum, 1023);
        check("ovf_sat", c_sat, 1);
`else
        check("ovf_sum", c_sum, 506);
`endif
        check("ovf_count", c_count, 3);
        for (int i = 0; i < 4; i++) send_c(8'd1, 8'd2, (i == 3));
        lat = 0;
        while (!c_ovalid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("wrap_sum", c_sum, 12);
        check("wrap_count", c_count, 0);
`ifdef ADDER_TREE_SAT_EN
        check("wrap_sat", c_sat, 0);
        check("b_sat", b_sat, 0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_tree_pipelined_acc.md
Name: adder_tree_pipelined_acc

Overview:
- Parametrised, pipelined successor to the combinational adder tree.
- Reduces an N-lane vector to one sum through registered tree levels, then accumulates successive vector sums over a group delimited by in_last.
- Valid/ready on both sides. Sits between a vector producer (filter/histogram lanes) and the trace buffer as the reduction stage.
- Supports signed/unsigned operands, arbitrary N (odd included) and configurable register density.

Parameters:
- N, 8, number of input lanes (>=1, odd allowed).
- IN_WIDTH, 32, width of each lane.
- SIGNED, 0, 1 = two's-complement operands and sign extension; 0 = zero extension.
- REG_EVERY, 1, insert a pipeline register after every REG_EVERY tree levels (>=1).
- ACC_WIDTH, IN_WIDTH+$clog2(N)+8, accumulator/output width.
- CNT_WIDTH, 16, width of the per-group vector counter.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, input vector valid.
- in_ready, out, 1, block can accept a vector this cycle.
- in_data, in, [IN_WIDTH-1:0] x [N-1:0], unpacked lane array.
- in_last, in, 1, this vector closes the current group.
- out_valid, out, 1, group sum valid.
- out_ready, in, 1, downstream accepts.
- out_sum, out, ACC_WIDTH, accumulated group sum.
- out_count, out, CNT_WIDTH, number of vectors in the group (wraps modulo 2^CNT_WIDTH).

Behaviour:
- LEVELS = $clog2(N); TREG = ceil(LEVELS/REG_EVERY), so TREG = 0 when N = 1.
- Level k sums adjacent pairs. An odd trailing element passes through unchanged.
- Each level grows width by 1 bit, sign- or zero-extended per SIGNED, so there is no intermediate overflow.
- The tree result is extended to ACC_WIDTH before accumulation.
- Pipeline enable: en = !out_valid || out_ready.
  - in_ready = en.
  - All tree registers, the valid/last shift chain, the accumulator and the output register advance only when en = 1. A stall freezes everything, with no bubbles lost.
- Transfer occurs when in_valid && in_ready. A valid bit and a last bit travel with each vector through the TREG stages.
- Accumulator stage (1 register), on an arriving valid beat:
  - s = acc + tree_sum (modulo 2^ACC_WIDTH); c = cnt + 1.
  - If last = 0: acc <= s, cnt <= c. No output.
  - If last = 1: out_sum <= s, out_count <= c, out_valid <= 1; then acc <= 0, cnt <= 0.
- Output hold: out_valid clears on an out_ready handshake unless a new last beat loads in the same cycle (back-to-back groups at full rate).
- Latency from accepted last vector to out_valid = TREG + 1 cycles with no stall. Throughput is 1 vector/cycle.
- A group of one vector (in_last = 1 every beat) yields plain tree sums, each with out_count = 1.
- Boundary behaviour:
  - cnt wraps 2^CNT_WIDTH-1 -> 0 silently.
  - Accumulator wraps modulo unless saturation is enabled (see Optional Feature).
  - in_valid = 0 beats never touch acc or cnt.
- Reset (asynchronous, any time, including mid-group or while stalled):
  - All valid bits, tree registers, acc, cnt, out_sum and out_count go to 0; out_valid = 0.
  - A partially accumulated group is discarded.
  - in_ready = 1 in the first cycle after deassertion.

Optional Feature:
- Macro ADDER_TREE_SAT_EN.
- Defined:
  - Accumulator add saturates: unsigned clamps to 2^ACC_WIDTH-1; signed clamps to the max/min representable value.
  - Extra output port out_sat, 1 bit, set if any add in the emitted group saturated. Its reset value is 0.
  - The sticky flag clears with acc.
- Undefined: modulo wrap and no out_sat port.

Decomposition:
- Package adder_tree_pkg holds:
  - functions tree_levels(N) and level_count(N,k) (= ceil(N/2^k));
  - localparam helper for TREG;
  - a typedef for the valid/last sideband struct.
- One natural sub-module: tree_level_reg, which performs one pairwise-add level (odd passthrough, width+1, SIGNED extension) with an optional output register gated by en. It is instantiated in a generate loop, registered when (k+1) % REG_EVERY == 0 or at the final level.

Test Plan:
- N=8, SIGNED=0: lanes 1..8, in_last=1 -> out_sum=36, out_count=1, out_valid exactly TREG+1 = 4 cycles after accept (REG_EVERY=1).
- N=5, SIGNED=1, IN_WIDTH=8: lanes {-128,-1,127,3,-2}, in_last=1 -> out_sum=-1 sign-correct (all ACC_WIDTH bits set); odd passthrough verified.
- Group of 3 vectors of all-ones lanes (N=8), last on third, streamed back-to-back with a following 1-vector group of all 2s -> out_sum=24/count=3, then out_sum=16/count=1 on consecutive cycles.
- out_ready held 0 for 5 cycles while in_valid stays 1 -> in_ready=0, out_sum/out_count stable, no vector lost or duplicated after release (scoreboard match).
- Assert rst for 1 cycle after 2 non-last vectors -> all outputs 0; next 1-vector group of 1..8 gives out_sum=36, count=1 (stale partial sum discarded).
- ADDER_TREE_SAT_EN, ACC_WIDTH=10, unsigned, 3 vectors of lanes 255 (N=2) -> out_sum=1023, out_sat=1. Without the macro: out_sum=1530 mod 1024 = 506.
